// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-deep x 8-bit sync FIFO and its read-side consumers.
// Holds the FIFO geometry and the slot-to-lane mapping used by word packers.
// No ports; imported by fifo_rd_packer.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 8;

  // Output lane that receives accumulation slot 'slot' in a 'bytes'-lane word.
  // le != 0: first byte lands in lane 0; otherwise it lands in the top lane.
  function automatic int lane_idx(input int slot, input int bytes, input int le);
    return (le != 0) ? slot : (bytes - 1 - slot);
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Purpose: pops bytes from a show-ahead sync FIFO and packs BYTES of them into one output word; flush closes a partial word.
// Latency: a word is presented at the same edge as its completing pop (or its accepted flush); zero extra cycles.
// Backpressure: word_valid/word_ready; while a word is held, pops continue until one slot is left, then stall.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fifo_empty, rd_data        FIFO empty flag and show-ahead head byte
//   rd_enb                     pop strobe (never high while fifo_empty or in reset)
//   flush                      single-cycle request to close the current partial word
//   word_data/keep/last/valid  packed output word, lane mask, flush-closed flag, valid
//   word_ready                 downstream accept
//   flush_busy                 flush accepted but partial word not yet loaded into the output regs
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_W        = FIFO_DATA_W,
  parameter int BYTES         = 4,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fifo_empty,
  input  logic [DATA_W-1:0]         rd_data,
  output logic                      rd_enb,
  input  logic                      flush,
  output logic [DATA_W*BYTES-1:0]   word_data,
  output logic [BYTES-1:0]          word_keep,
  output logic                      word_last,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic                      flush_busy
);

  localparam int CW = $clog2(BYTES + 1);
  localparam int WW = DATA_W * BYTES;
  localparam logic [CW-1:0] LAST_SLOT = CW'(BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(BYTES);

  logic [DATA_W-1:0] acc [BYTES];
  logic [CW-1:0]     acc_cnt;
  logic              flush_pend;

  logic              out_free;
  logic              pop;
  logic [DATA_W-1:0] acc_nx [BYTES];
  logic [CW-1:0]     cnt_after;
  logic [CW-1:0]     acc_cnt_nx;
  logic [CW-1:0]     load_cnt;
  logic              load;
  logic              last_nx;
  logic              flush_pend_nx;
  logic [WW-1:0]     data_nx;
  logic [BYTES-1:0]  keep_nx;

  assign out_free   = !word_valid || word_ready;
  // The final slot may only be filled when the output regs can take the word
  // at that same edge, so acc_cnt never reaches BYTES.
  assign pop        = rst_n && !fifo_empty && !flush_pend &&
                      ((acc_cnt < LAST_SLOT) || out_free);
  assign rd_enb     = pop;
  assign flush_busy = flush_pend;
  assign cnt_after  = acc_cnt + CW'(pop);

  // Accumulator contents including a pop happening at this edge, so a word
  // completed or flushed at this edge carries the byte being popped.
  always_comb begin
    acc_nx = acc;
    for (int s = 0; s < BYTES; s++) begin
      if (pop && (acc_cnt == CW'(s))) begin
        acc_nx[s] = rd_data;
      end
    end
  end

  // Decide whether the output regs load this edge, and with how many slots.
  always_comb begin
    load          = 1'b0;
    load_cnt      = '0;
    last_nx       = 1'b0;
    acc_cnt_nx    = cnt_after;
    flush_pend_nx = flush_pend;
    if (flush_pend) begin
      // Pops are blocked while pending, so acc_cnt is the partial length;
      // any new flush request is ignored here.
      if (out_free) begin
        load          = 1'b1;
        load_cnt      = acc_cnt;
        last_nx       = 1'b1;
        acc_cnt_nx    = '0;
        flush_pend_nx = 1'b0;
      end
    end else if (pop && (acc_cnt == LAST_SLOT)) begin
      load       = 1'b1;
      load_cnt   = FULL_CNT;
      last_nx    = flush;
      acc_cnt_nx = '0;
    end else if (flush && (cnt_after != '0)) begin
      if (out_free) begin
        load       = 1'b1;
        load_cnt   = cnt_after;
        last_nx    = 1'b1;
        acc_cnt_nx = '0;
      end else begin
        flush_pend_nx = 1'b1;
      end
    end
  end

  // Place filled slots into their lanes; lanes beyond load_cnt stay zero.
  always_comb begin
    data_nx = '0;
    keep_nx = '0;
    for (int s = 0; s < BYTES; s++) begin
      if (CW'(s) < load_cnt) begin
        data_nx[lane_idx(s, BYTES, LITTLE_ENDIAN)*DATA_W +: DATA_W] = acc_nx[s];
        keep_nx[lane_idx(s, BYTES, LITTLE_ENDIAN)]                  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < BYTES; s++) begin
        acc[s] <= '0;
      end
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_keep  <= '0;
      word_last  <= 1'b0;
    end else begin
      acc        <= acc_nx;
      acc_cnt    <= acc_cnt_nx;
      flush_pend <= flush_pend_nx;
      if (load) begin
        word_valid <= 1'b1;
        word_data  <= data_nx;
        word_keep  <= keep_nx;
        word_last  <= last_nx;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a little-endian instance fed by a queue-based FIFO model with a
// scoreboard of expected words, plus a big-endian instance exercised with fixed sequences.
// Also watches for pops issued against an empty FIFO.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int NB = 4;
  localparam int WW = DW * NB;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // little-endian instance
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] rd_data    = '0;
  logic          rd_enb, flush, word_last, word_valid, word_ready, flush_busy;
  logic [WW-1:0] word_data;
  logic [NB-1:0] word_keep;

  // big-endian instance
  logic          b_empty = 1'b1;
  logic [DW-1:0] b_rd_data = '0;
  logic          b_rd_enb, b_flush, b_last, b_valid, b_ready, b_busy;
  logic [WW-1:0] b_data;
  logic [NB-1:0] b_keep;

  fifo_rd_packer #(.DATA_W(DW), .BYTES(NB), .LITTLE_ENDIAN(1)) u_le (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .rd_data(rd_data), .rd_enb(rd_enb),
    .flush(flush), .word_data(word_data), .word_keep(word_keep), .word_last(word_last),
    .word_valid(word_valid), .word_ready(word_ready), .flush_busy(flush_busy)
  );

  fifo_rd_packer #(.DATA_W(DW), .BYTES(NB), .LITTLE_ENDIAN(0)) u_be (
    .clk(clk), .rst_n(rst_n), .fifo_empty(b_empty), .rd_data(b_rd_data), .rd_enb(b_rd_enb),
    .flush(b_flush), .word_data(b_data), .word_keep(b_keep), .word_last(b_last),
    .word_valid(b_valid), .word_ready(b_ready), .flush_busy(b_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired before the required condition", name);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- FIFO models (8 deep, show-ahead) ----------------
  logic [7:0] fq[$];
  logic       wr = 1'b0;
  logic [7:0] wr_dat = '0;
  int         pop_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_empty <= 1'b1;
      rd_data    <= '0;
    end else begin
      check("le_underrun", {63'd0, rd_enb && (fq.size() == 0)}, 64'd0);
      if (rd_enb && fq.size() > 0) begin
        void'(fq.pop_front());
        pop_cnt++;
      end
      if (wr) fq.push_back(wr_dat);
      fifo_empty <= (fq.size() == 0);
      rd_data    <= (fq.size() > 0) ? fq[0] : 8'h00;
    end
  end

  logic [7:0] bq[$];
  logic       b_wr = 1'b0;
  logic [7:0] b_wr_dat = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bq.delete();
      b_empty   <= 1'b1;
      b_rd_data <= '0;
    end else begin
      check("be_underrun", {63'd0, b_rd_enb && (bq.size() == 0)}, 64'd0);
      if (b_rd_enb && bq.size() > 0) void'(bq.pop_front());
      if (b_wr) bq.push_back(b_wr_dat);
      b_empty   <= (bq.size() == 0);
      b_rd_data <= (bq.size() > 0) ? bq[0] : 8'h00;
    end
  end

  // ---------------- reference model: byte stream chunked into words ----------------
  word_t      expq[$];
  logic [7:0] part[$];

  task automatic close_word(input logic last);
    word_t w;
    w = '0;
    foreach (part[i]) begin
      w.data[8*i +: 8] = part[i];
      w.keep[i]        = 1'b1;
    end
    w.last = last;
    expq.push_back(w);
    part.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    part.push_back(b);
    if (part.size() == NB) close_word(1'b0);
  endtask

  task automatic put(input logic [7:0] b);
    int n;
    n = 0;
    while (fq.size() >= 8 && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) fail("fifo_space");
    wr     = 1'b1;
    wr_dat = b;
    model_byte(b);
    tick(1);
    wr = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    if (part.size() > 0) close_word(1'b1);
    tick(1);
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || fq.size() != 0) && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) fail(name);
  endtask

  task automatic b_put(input logic [7:0] b);
    b_wr     = 1'b1;
    b_wr_dat = b;
    tick(1);
    b_wr = 1'b0;
  endtask

  // ---------------- monitors ----------------
  word_t         mon_e;
  int            valid_cycles = 0;
  int            busy_cycles  = 0;
  logic [WW-1:0] last_word = '0;
  logic [NB-1:0] last_keep = '0;
  logic          last_last = 1'b0;
  word_t         bobs[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (word_valid) valid_cycles++;
      if (flush_busy) busy_cycles++;
      if (word_valid && word_ready) begin
        last_word = word_data;
        last_keep = word_keep;
        last_last = word_last;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h last %0b, required no word",
                   word_data, word_keep, word_last);
        end else begin
          mon_e = expq.pop_front();
          check("word_data", {32'd0, word_data}, {32'd0, mon_e.data});
          check("word_keep", {60'd0, word_keep}, {60'd0, mon_e.keep});
          check("word_last", {63'd0, word_last}, {63'd0, mon_e.last});
        end
      end
      if (b_valid && b_ready) bobs.push_back('{data: b_data, keep: b_keep, last: b_last});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    rst_n      = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b0;
    b_flush    = 1'b0;
    b_ready    = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", {63'd0, word_valid}, 64'd0);
    check("rst_data",  {32'd0, word_data},  64'd0);
    check("rst_keep",  {60'd0, word_keep},  64'd0);
    check("rst_busy",  {63'd0, flush_busy}, 64'd0);
    check("rst_rd_enb", {63'd0, rd_enb},    64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // full word, ready high
    word_ready   = 1'b1;
    pop_cnt      = 0;
    valid_cycles = 0;
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    wait_idle("t1_idle");
    tick(2);
    check("t1_pops", pop_cnt, 4);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_word", {32'd0, last_word}, 64'h44332211);

    // held output, pops stall with one slot left
    word_ready = 1'b0;
    for (int b = 1; b <= 8; b++) put(8'(b));
    tick(6);
    check("t2_valid", {63'd0, word_valid}, 64'd1);
    check("t2_held_data", {32'd0, word_data}, 64'h04030201);
    check("t2_rd_enb", {63'd0, rd_enb}, 64'd0);
    check("t2_fifo_count", fq.size(), 1);
    word_ready = 1'b1;
    wait_idle("t2_idle");
    tick(2);
    check("t2_word2", {32'd0, last_word}, 64'h08070605);

    // flush of a two-byte partial word
    put(8'hAA); put(8'hBB);
    wait_idle("t3_drain");
    do_flush();
    wait_idle("t3_idle");
    tick(2);
    check("t3_word", {32'd0, last_word}, 64'h0000BBAA);
    check("t3_keep", {60'd0, last_keep}, 64'h3);
    check("t3_last", {63'd0, last_last}, 64'd1);

    // flush with nothing accumulated
    valid_cycles = 0;
    busy_cycles  = 0;
    do_flush();
    tick(4);
    check("t4_valid_cycles", valid_cycles, 0);
    check("t4_busy_cycles", busy_cycles, 0);

    // reset with two bytes accumulated and a word held
    word_ready = 1'b0;
    for (int b = 0; b < 6; b++) put(8'h60 + 8'(b));
    tick(4);
    check("t6_pre_valid", {63'd0, word_valid}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_valid", {63'd0, word_valid}, 64'd0);
    check("t6_data",  {32'd0, word_data},  64'd0);
    check("t6_keep",  {60'd0, word_keep},  64'd0);
    check("t6_last",  {63'd0, word_last},  64'd0);
    check("t6_busy",  {63'd0, flush_busy}, 64'd0);
    check("t6_rd_enb", {63'd0, rd_enb},    64'd0);
    expq.delete();
    part.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // randomized traffic, backpressure and flushes
    for (int it = 0; it < 500; it++) begin
      word_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 6 && fq.size() < 8) begin
        wr     = 1'b1;
        wr_dat = 8'($urandom);
        model_byte(wr_dat);
      end else if (r == 9 && fq.size() == 0 && !flush_busy) begin
        flush = 1'b1;
        if (part.size() > 0) close_word(1'b1);
      end
      tick(1);
      wr    = 1'b0;
      flush = 1'b0;
    end
    word_ready = 1'b1;
    wait_idle("rand_idle");
    if (part.size() > 0) begin
      do_flush();
      wait_idle("rand_final_flush");
    end
    tick(3);
    check("rand_leftover", expq.size(), 0);

    // big-endian lane placement and pending flush
    b_ready = 1'b1;
    b_put(8'h11); b_put(8'h22); b_put(8'h33); b_put(8'h44);
    tick(4);
    check("t5_words", bobs.size(), 1);
    if (bobs.size() >= 1) begin
      check("t5_word0", {32'd0, bobs[0].data}, 64'h11223344);
      check("t5_keep0", {60'd0, bobs[0].keep}, 64'hF);
    end
    b_ready = 1'b0;
    for (int b = 0; b < 7; b++) b_put(8'h55 + 8'(b) * 8'h11);
    tick(4);
    check("t5_held", {32'd0, b_data}, 64'h55667788);
    b_flush = 1'b1;
    tick(1);
    b_flush = 1'b0;
    check("t5_busy", {63'd0, b_busy}, 64'd1);
    b_put(8'hCC);
    tick(3);
    check("t5_rd_enb_blocked", {63'd0, b_rd_enb}, 64'd0);
    check("t5_fifo_count", bq.size(), 1);
    b_ready = 1'b1;
    tick(4);
    check("t5_words_after", bobs.size(), 3);
    if (bobs.size() >= 3) begin
      check("t5_word1", {32'd0, bobs[1].data}, 64'h55667788);
      check("t5_last1", {63'd0, bobs[1].last}, 64'd0);
      check("t5_word2", {32'd0, bobs[2].data}, 64'h99AABB00);
      check("t5_keep2", {60'd0, bobs[2].keep}, 64'hE);
      check("t5_last2", {63'd0, bobs[2].last}, 64'd1);
    end
    check("t5_busy_clear", {63'd0, b_busy}, 64'd0);
    check("t5_fifo_drained", bq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
